very_simple_cpu: RTL and testbench



---
 rtl/vscpu_pkg.sv | 30 +++
 rtl/very_simple_cpu_if.sv | 12 +
 rtl/vscpu_alu.sv | 31 +++
 rtl/very_simple_cpu.sv | 118 +++++++++++
 tb/tb_very_simple_cpu.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/vscpu_pkg.sv
// vscpu_pkg: shared opcode/state encodings and instruction-field positions
// for very_simple_cpu and its ALU.
package vscpu_pkg;

   localparam int unsigned FLD_W   = 14;
   localparam int unsigned OPC_LSB = 29;
   localparam int unsigned IMM_BIT = 28;
   localparam int unsigned A_LSB   = 14;
   localparam int unsigned B_LSB   = 0;

   typedef enum logic [2:0] {
      ADD  = 3'd0,
      NAND = 3'd1,
      SRL  = 3'd2,
      LT   = 3'd3,
      CP   = 3'd4,
      CPI  = 3'd5,
      BZJ  = 3'd6,
      MUL  = 3'd7
   } opcode_t;

   typedef enum logic [2:0] {
      FETCH = 3'd0,
      READA = 3'd1,
      READB = 3'd2,
      EXEC  = 3'd3,
      INDIR = 3'd4
   } state_t;

endpackage

// File: rtl/very_simple_cpu_if.sv
// very_simple_cpu_if: single-port synchronous RAM bus; the CPU is the only master.
interface very_simple_cpu_if #(
   parameter int SIZE = 14
);
   logic            wrEn;
   logic [SIZE-1:0] addr_toRAM;
   logic [31:0]     data_toRAM;
   logic [31:0]     data_fromRAM;

   modport master (output wrEn, output addr_toRAM, output data_toRAM, input data_fromRAM);
   modport slave  (input wrEn, input addr_toRAM, input data_toRAM, output data_fromRAM);
endinterface

// File: rtl/vscpu_alu.sv
// vscpu_alu: combinational datapath for ADD/NAND/SRL/LT/CP and, when
// VSCPU_MUL_EN is defined, MUL.
module vscpu_alu
   import vscpu_pkg::*;
(
   input  opcode_t     opcode,
   input  logic [31:0] r1,
   input  logic [31:0] y,
   output logic [31:0] result
);

   always_comb begin
      result = '0;
      case (opcode)
         ADD:  result = r1 + y;
         NAND: result = ~(r1 & y);
         // Amounts 32..63 turn into a left shift; anything past that shifts out to zero.
         SRL:  begin
            if (y < 32'd32) result = r1 >> y[4:0];
            else            result = r1 << (y - 32'd32);
         end
         LT:   result = 32'(r1 < y);
         CP:   result = y;
`ifdef VSCPU_MUL_EN
         MUL:  result = r1 * y;
`endif
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/very_simple_cpu.sv
// very_simple_cpu: multi-cycle memory-to-memory CPU (FETCH/READA/READB/EXEC[/INDIR]).
// Define VSCPU_MUL_EN to build the multiplier; otherwise opcode 111 is a NOP.
module very_simple_cpu
   import vscpu_pkg::*;
#(
   parameter int SIZE = 14
) (
   input logic               clk,
   input logic               rst,
   very_simple_cpu_if.master bus
);

   state_t          state, state_n;
   logic [SIZE-1:0] pc, pc_n, pc_inc, a_addr, b_addr;
   logic [31:0]     iw, iw_n, r1, r1_n, x, y, alu_res;
   opcode_t         opc;
   logic            imm;

   assign opc    = opcode_t'(iw[OPC_LSB +: 3]);
   assign imm    = iw[IMM_BIT];
   assign a_addr = SIZE'(iw[A_LSB +: FLD_W]);
   assign b_addr = SIZE'(iw[B_LSB +: FLD_W]);
   assign pc_inc = pc + SIZE'(1);
   assign x      = bus.data_fromRAM;
   assign y      = imm ? 32'(iw[B_LSB +: FLD_W]) : x;

   vscpu_alu u_alu (
      .opcode (opc),
      .r1     (r1),
      .y      (y),
      .result (alu_res)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH;
         pc    <= '0;
         iw    <= '0;
         r1    <= '0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         iw    <= iw_n;
         r1    <= r1_n;
      end
   end

   always_comb begin
      state_n         = state;
      pc_n            = pc;
      iw_n            = iw;
      r1_n            = r1;
      bus.wrEn        = 1'b0;
      bus.addr_toRAM  = '0;
      bus.data_toRAM  = '0;
      case (state)
         FETCH: begin
            bus.addr_toRAM = pc;
            state_n        = READA;
         end
         READA: begin
            iw_n           = x;
            bus.addr_toRAM = SIZE'(x[A_LSB +: FLD_W]);
            state_n        = READB;
         end
         READB: begin
            r1_n           = x;
            bus.addr_toRAM = b_addr;
            state_n        = EXEC;
         end
         EXEC: begin
            state_n = FETCH;
            pc_n    = pc_inc;
            case (opc)
               CPI: begin
                  if (!imm) begin
                     // *A = *(*B): fetch the pointed-to word, write it in INDIR.
                     bus.addr_toRAM = SIZE'(x[B_LSB +: FLD_W]);
                     pc_n           = pc;
                     state_n        = INDIR;
                  end else begin
                     bus.wrEn       = 1'b1;
                     bus.addr_toRAM = SIZE'(r1[B_LSB +: FLD_W]);
                     bus.data_toRAM = x;
                  end
               end
               BZJ: begin
                  if (imm)           pc_n = r1[SIZE-1:0] + b_addr;
                  else if (x == '0)  pc_n = r1[SIZE-1:0];
               end
`ifndef VSCPU_MUL_EN
               MUL: pc_n = pc_inc;
`endif
               default: begin
                  bus.wrEn       = 1'b1;
                  bus.addr_toRAM = a_addr;
                  bus.data_toRAM = alu_res;
               end
            endcase
         end
         INDIR: begin
            bus.wrEn       = 1'b1;
            bus.addr_toRAM = a_addr;
            bus.data_toRAM = x;
            pc_n           = pc_inc;
            state_n        = FETCH;
         end
         default: state_n = FETCH;
      endcase
      // Bus held quiet while reset is asserted, even mid-instruction.
      if (rst) begin
         bus.wrEn       = 1'b0;
         bus.addr_toRAM = '0;
         bus.data_toRAM = '0;
      end
   end

endmodule

// File: tb/tb_very_simple_cpu.sv
// tb_very_simple_cpu: directed program in a behavioural RAM; expected bus events
// are queued per cycle and checked by an independent negedge monitor.
module tb_very_simple_cpu;
   import vscpu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   very_simple_cpu_if #(.SIZE(14)) bus ();
   very_simple_cpu #(.SIZE(14)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   logic [31:0] mem [0:16383];
   logic [31:0] rd_q = '0;
   assign bus.data_fromRAM = rd_q;

   always @(posedge clk) begin
      rd_q <= mem[bus.addr_toRAM];
      if (bus.wrEn) mem[bus.addr_toRAM] = bus.data_toRAM;
   end

   typedef struct {
      int unsigned cyc;
      logic        wr;
      logic [13:0] addr;
      logic [31:0] data;
   } ev_t;

   ev_t         sb[$];
   ev_t         mon_e;
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;
   int unsigned t = 0;
   bit          mon_en = 1'b0;

   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [2:0] op, input logic imm,
                                       input int unsigned a, input int unsigned b);
      logic [13:0] a14, b14;
      a14 = a[13:0];
      b14 = b[13:0];
      return {op, imm, a14, b14};
   endfunction

   // Loads one instruction and queues its fetch, optional CPI indirect read, and write.
   task automatic prog(input int unsigned pc, input logic [31:0] w, input bit cpi,
                       input int unsigned mid, input bit wr, input int unsigned wa,
                       input logic [31:0] wd);
      mem[pc] = w;
      sb.push_back('{t, 1'b0, 14'(pc), 32'h0});
      if (cpi) begin
         sb.push_back('{t + 3, 1'b0, 14'(mid), 32'h0});
         sb.push_back('{t + 4, 1'b1, 14'(wa), wd});
         t += 5;
      end else begin
         if (wr) sb.push_back('{t + 3, 1'b1, 14'(wa), wd});
         t += 4;
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (sb.size() != 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            check($sformatf("wrEn@c%0d", cyc), 32'(bus.wrEn), 32'(mon_e.wr));
            check($sformatf("addr@c%0d", cyc), 32'(bus.addr_toRAM), 32'(mon_e.addr));
            if (mon_e.wr) check($sformatf("data@c%0d", cyc), bus.data_toRAM, mon_e.data);
         end else begin
            check($sformatf("no_write@c%0d", cyc), 32'(bus.wrEn), 32'h0);
         end
      end
   end

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = '0;
      mem[69]  = 32'd1;        mem[70]  = 32'd1000;     mem[100] = 32'd6;
      mem[110] = 32'h80;       mem[111] = 32'h80;       mem[112] = 32'h0;
      mem[113] = 32'd3;        mem[114] = 32'd11;
      mem[115] = 32'hF0000001; mem[116] = 32'd64;
      mem[117] = 32'h80000001; mem[118] = 32'd32;
      mem[119] = 32'hFFFFFFFF; mem[120] = 32'd1;
      mem[122] = 32'hFFFFFFFF; mem[123] = 32'd2;
      mem[130] = 32'd20;       mem[131] = 32'd5;        mem[132] = 32'd0;
      mem[143] = 32'hFFFFFFFF; mem[150] = 32'd0;
      mem[15]  = enc(CP, 1'b0, 140, 141);

      prog(0,  enc(NAND, 1'b0, 69, 69),     0, 0,    1, 69,   32'hFFFFFFFE);
      prog(1,  enc(ADD,  1'b0, 100, 69),    0, 0,    1, 100,  32'h00000004);
      prog(2,  enc(CPI,  1'b1, 70, 100),    0, 0,    1, 1000, 32'h00000004);
      prog(3,  enc(CPI,  1'b0, 101, 70),    1, 1000, 1, 101,  32'h00000004);
      prog(4,  enc(SRL,  1'b1, 110, 3),     0, 0,    1, 110,  32'h00000010);
      prog(5,  enc(SRL,  1'b1, 111, 33),    0, 0,    1, 111,  32'h00000100);
      prog(6,  enc(LT,   1'b1, 112, 1),     0, 0,    1, 112,  32'h00000001);
`ifdef VSCPU_MUL_EN
      prog(7,  enc(MUL,  1'b0, 113, 114),   0, 0,    1, 113,  32'd33);
`else
      prog(7,  enc(MUL,  1'b0, 113, 114),   0, 0,    0, 0,    32'h0);
`endif
      prog(8,  enc(SRL,  1'b0, 115, 116),   0, 0,    1, 115,  32'h00000000);
      prog(9,  enc(SRL,  1'b0, 117, 118),   0, 0,    1, 117,  32'h80000001);
      prog(10, enc(LT,   1'b0, 119, 120),   0, 0,    1, 119,  32'h00000000);
      prog(11, enc(CP,   1'b0, 121, 110),   0, 0,    1, 121,  32'h00000010);
      prog(12, enc(ADD,  1'b0, 122, 123),   0, 0,    1, 122,  32'h00000001);
      prog(13, enc(BZJ,  1'b0, 130, 131),   0, 0,    0, 0,    32'h0);
      prog(14, enc(BZJ,  1'b0, 130, 132),   0, 0,    0, 0,    32'h0);
      prog(20, enc(CP,   1'b1, 142, 16'h1234), 0, 0, 1, 142,  32'h00001234);
      prog(21, enc(NAND, 1'b1, 143, 16'h3FFF), 0, 0, 1, 143,  32'hFFFFC000);
      prog(22, enc(BZJ,  1'b1, 150, 22),    0, 0,    0, 0,    32'h0);
      for (int i = 0; i < 29; i++) begin
         sb.push_back('{t, 1'b0, 14'd22, 32'h0});
         t += 4;
      end

      repeat (10) begin
         @(negedge clk);
         check("reset_wrEn", 32'(bus.wrEn), 32'h0);
         check("reset_addr", 32'(bus.addr_toRAM), 32'h0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;

      for (int i = 0; i < 800 && sb.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'h0);
      mon_en = 1'b0;

      // Abort an instruction in its write cycle and confirm nothing lands.
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("exec_wrEn", 32'(bus.wrEn), 32'h1);
      check("exec_addr", 32'(bus.addr_toRAM), 32'd69);
      check("exec_data", bus.data_toRAM, 32'h00000001);
      rst = 1'b1;
      #1;
      check("abort_wrEn", 32'(bus.wrEn), 32'h0);
      check("abort_addr", 32'(bus.addr_toRAM), 32'h0);
      check("abort_data", bus.data_toRAM, 32'h0);
      repeat (3) @(negedge clk);
      check("abort_mem69", mem[69], 32'hFFFFFFFE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
